// File: rtl/request_decoder.sv
// Two-byte request decoder: validates a request code and a sensor address,
// then presents a one-hot device select over a valid/ready handshake.
module request_decoder #(
  parameter int unsigned NUM_DEVICES    = 32,
  parameter logic [7:0]  BASE_ADDRESS   = 8'h20,
  parameter logic [7:0]  MAX_REQUEST    = 8'h07,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   has_request,
  input  logic [7:0]             received_data,
  input  logic                   request_ready,
  output logic [7:0]             request,
  output logic [NUM_DEVICES-1:0] device_selector,
  output logic                   request_valid,
  output logic                   error_valid,
  output logic [1:0]             error_code,
  output logic                   busy
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES);
  // The timeout fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [8:0]       ADDR_LO   = {1'b0, BASE_ADDRESS};
  localparam logic [8:0]       ADDR_HI   = ADDR_LO + 9'(NUM_DEVICES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT_ADDRESS, S_CHECK, S_ISSUE
  } state_t;

  typedef enum logic [1:0] {
    ERR_OVERRUN = 2'b00,
    ERR_ADDRESS = 2'b01,
    ERR_COMMAND = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  state_t                 r_state, w_next_state;
  logic [CNT_W-1:0]       r_count;
  logic [7:0]             r_address;
  logic [7:0]             r_request;
  logic [NUM_DEVICES-1:0] r_selector;
  logic                   r_valid;
  logic                   r_error_valid;
  err_t                   r_error_code;

  logic [8:0]             w_offset;
  logic [NUM_DEVICES-1:0] w_onehot;
  logic                   w_addr_bad, w_cmd_bad, w_timeout;
  logic                   w_load_request, w_load_address, w_count_en;
  logic                   w_select_load, w_issue, w_retire, w_error;
  err_t                   w_error_code;

  // Range test in 9 bits so a high base plus many slots cannot wrap past 8'hFF.
  assign w_offset   = {1'b0, r_address} - ADDR_LO;
  assign w_addr_bad = ({1'b0, r_address} < ADDR_LO) || ({1'b0, r_address} > ADDR_HI);
  assign w_cmd_bad  = (r_request > MAX_REQUEST);
  assign w_timeout  = (r_count == LAST_WAIT);

  always_comb begin
    for (int k = 0; k < NUM_DEVICES; k++) begin
      w_onehot[k] = (w_offset == 9'(k));
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:         if (has_request) w_next_state = S_WAIT_ADDRESS;
      S_WAIT_ADDRESS: begin
        if (has_request)    w_next_state = S_CHECK;
        else if (w_timeout) w_next_state = S_IDLE;
      end
      S_CHECK:        w_next_state = (w_addr_bad || w_cmd_bad) ? S_IDLE : S_ISSUE;
      S_ISSUE:        if (request_ready) w_next_state = has_request ? S_WAIT_ADDRESS : S_IDLE;
      default:        w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_load_request = 1'b0;
    w_load_address = 1'b0;
    w_count_en     = 1'b0;
    w_select_load  = 1'b0;
    w_issue        = 1'b0;
    w_retire       = 1'b0;
    w_error        = 1'b0;
    w_error_code   = ERR_OVERRUN;
    case (r_state)
      S_IDLE:         w_load_request = has_request;
      S_WAIT_ADDRESS: begin
        w_load_address = has_request;
        w_count_en     = !has_request && !w_timeout;
        if (!has_request && w_timeout) begin
          w_error      = 1'b1;
          w_error_code = ERR_TIMEOUT;
        end
      end
      S_CHECK: begin
        w_select_load = 1'b1;
        if (w_addr_bad) begin
          w_error      = 1'b1;
          w_error_code = ERR_ADDRESS;
        end else if (w_cmd_bad) begin
          w_error      = 1'b1;
          w_error_code = ERR_COMMAND;
        end else begin
          w_issue = 1'b1;
          // A byte arriving while the command is judged is an overrun.
          w_error = has_request;
        end
      end
      S_ISSUE: begin
        if (request_ready) begin
          w_retire       = 1'b1;
          w_load_request = has_request;
        end else begin
          w_error = has_request;
        end
      end
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count       <= '0;
      r_address     <= '0;
      r_request     <= '0;
      r_selector    <= '0;
      r_valid       <= 1'b0;
      r_error_valid <= 1'b0;
      r_error_code  <= ERR_OVERRUN;
    end else begin
      r_error_valid <= w_error;
      if (w_error) r_error_code <= w_error_code;
      if (w_load_request) begin
        r_request <= received_data;
        r_count   <= '0;
      end else if (w_count_en) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_load_address) r_address <= received_data;
      // The selector keeps the sensor enabled after retirement until the next CHECK.
      if (w_select_load) r_selector <= w_issue ? w_onehot : '0;
      if (w_issue)       r_valid <= 1'b1;
      else if (w_retire) r_valid <= 1'b0;
    end
  end

  assign request         = r_request;
  assign device_selector = r_selector;
  assign request_valid   = r_valid;
  assign error_valid     = r_error_valid;
  assign error_code      = r_error_code;

endmodule

// File: tb/tb_request_decoder.sv
// Self-checking bench for request_decoder: directed scenarios plus randomized
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_request_decoder;

  localparam int         NUM     = 32;
  localparam int         BASE    = 8'h20;
  localparam int         MAXREQ  = 8'h07;
  localparam int         TIMEOUT = 16;

  logic            clock;
  logic            reset;
  logic            has_request;
  logic [7:0]      received_data;
  logic            request_ready;
  logic [7:0]      request;
  logic [NUM-1:0]  device_selector;
  logic            request_valid;
  logic            error_valid;
  logic [1:0]      error_code;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  request_decoder #(
    .NUM_DEVICES   (NUM),
    .BASE_ADDRESS  (8'h20),
    .MAX_REQUEST   (8'h07),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .has_request    (has_request),
    .received_data  (received_data),
    .request_ready  (request_ready),
    .request        (request),
    .device_selector(device_selector),
    .request_valid  (request_valid),
    .error_valid    (error_valid),
    .error_code     (error_code),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Transaction view: which bytes are held, how long since the request byte,
  // and whether an issued command is still outstanding.
  typedef struct {
    bit             waiting;
    bit             have_addr;
    bit             outstanding;
    int             age;
    logic [7:0]     req;
    logic [7:0]     addr;
    logic [NUM-1:0] sel;
    bit             valid;
    bit             ev;
    logic [1:0]     code;
  } model_t;

  model_t m;

  function automatic model_t model_clear();
    model_t z;
    z.waiting = 0; z.have_addr = 0; z.outstanding = 0; z.age = 0;
    z.req = '0; z.addr = '0; z.sel = '0; z.valid = 0; z.ev = 0; z.code = 2'b00;
    return z;
  endfunction

  function automatic model_t model_step(model_t c, logic h, logic [7:0] d, logic r);
    model_t n;
    int     a;
    n    = c;
    n.ev = 0;
    if (c.have_addr) begin
      n.have_addr = 0;
      a = int'(c.addr);
      if (a < BASE || a > BASE + NUM - 1) begin
        n.ev = 1; n.code = 2'b01; n.sel = '0;
      end else if (int'(c.req) > MAXREQ) begin
        n.ev = 1; n.code = 2'b10; n.sel = '0;
      end else begin
        n.sel = NUM'(1) << (a - BASE);
        n.valid = 1; n.outstanding = 1;
        if (h) begin n.ev = 1; n.code = 2'b00; end
      end
    end else if (c.waiting) begin
      n.age = c.age + 1;
      if (h) begin
        n.addr = d; n.have_addr = 1; n.waiting = 0;
      end else if (n.age == TIMEOUT - 1) begin
        n.ev = 1; n.code = 2'b11; n.waiting = 0;
      end
    end else if (c.outstanding) begin
      if (r) begin
        n.valid = 0; n.outstanding = 0;
        if (h) begin n.req = d; n.waiting = 1; n.age = 0; end
      end else if (h) begin
        n.ev = 1; n.code = 2'b00;
      end
    end else if (h) begin
      n.req = d; n.waiting = 1; n.age = 0;
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= model_clear();
    else       m <= model_step(m, has_request, received_data, request_ready);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    check("request",         64'(request),         64'(m.req));
    check("device_selector", 64'(device_selector), 64'(m.sel));
    check("request_valid",   64'(request_valid),   64'(m.valid));
    check("error_valid",     64'(error_valid),     64'(m.ev));
    check("error_code",      64'(error_code),      64'(m.code));
    check("busy",            64'(busy),            64'(m.waiting || m.have_addr || m.outstanding));
  end

  task automatic cyc(input logic h, input logic [7:0] d, input logic r);
    @(negedge clock);
    has_request   = h;
    received_data = d;
    request_ready = r;
    @(posedge clock);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_request"},  64'(request),         64'(0));
    check({tag, "_selector"}, 64'(device_selector), 64'(0));
    check({tag, "_valid"},    64'(request_valid),   64'(0));
    check({tag, "_ev"},       64'(error_valid),     64'(0));
    check({tag, "_code"},     64'(error_code),      64'(0));
    check({tag, "_busy"},     64'(busy),            64'(0));
  endtask

  initial begin
    int         p_req;
    int         p_rdy;
    int         pick;
    logic       h;
    logic       r;
    logic [7:0] d;

    reset         = 1'b1;
    has_request   = 1'b0;
    received_data = 8'h00;
    request_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all_zero("reset");

    // Basic decode with ready held high.
    cyc(1, 8'h03, 1);
    cyc(1, 8'h20, 1);
    cyc(0, 8'h00, 1);
    check("t1_valid", 64'(request_valid), 64'(1));
    check("t1_req",   64'(request),       64'(8'h03));
    check("t1_sel",   64'(device_selector), 64'(32'h1));
    cyc(0, 8'h00, 1);
    check("t1_retired", 64'(request_valid), 64'(0));
    check("t1_idle",    64'(busy),          64'(0));

    // Highest slot, ready withheld for 5 cycles.
    cyc(1, 8'h01, 0);
    cyc(1, 8'h3F, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 0);
      check("t2_hold_valid", 64'(request_valid), 64'(1));
      check("t2_hold_sel",   64'(device_selector), 64'(32'h8000_0000));
    end
    cyc(0, 8'h00, 1);
    check("t2_drop", 64'(request_valid), 64'(0));

    // Overrun while the command waits.
    cyc(1, 8'h01, 0);
    cyc(1, 8'h3F, 0);
    cyc(0, 8'h00, 0);
    cyc(1, 8'h55, 0);
    check("t2_ovr_ev",    64'(error_valid),   64'(1));
    check("t2_ovr_code",  64'(error_code),    64'(0));
    check("t2_ovr_valid", 64'(request_valid), 64'(1));
    check("t2_ovr_req",   64'(request),       64'(8'h01));
    cyc(0, 8'h00, 1);
    check("t2_ovr_ev_once", 64'(error_valid), 64'(0));

    // Address and command rejection, address taking priority.
    cyc(1, 8'h01, 1);
    cyc(1, 8'h40, 1);
    cyc(0, 8'h00, 1);
    check("t3_addr_ev",   64'(error_valid),     64'(1));
    check("t3_addr_code", 64'(error_code),      64'(2'b01));
    check("t3_addr_sel",  64'(device_selector), 64'(0));
    check("t3_addr_val",  64'(request_valid),   64'(0));
    cyc(1, 8'h09, 1);
    cyc(1, 8'h20, 1);
    cyc(0, 8'h00, 1);
    check("t3_cmd_code", 64'(error_code), 64'(2'b10));
    cyc(1, 8'h09, 1);
    cyc(1, 8'h1F, 1);
    cyc(0, 8'h00, 1);
    check("t3_prio_code", 64'(error_code), 64'(2'b01));

    // Timeout after exactly 15 silent cycles.
    cyc(1, 8'h02, 1);
    for (int i = 1; i < 15; i++) cyc(0, 8'h00, 1);
    check("t4_not_yet", 64'(error_valid), 64'(0));
    check("t4_busy",    64'(busy),        64'(1));
    cyc(0, 8'h00, 1);
    check("t4_to_ev",   64'(error_valid), 64'(1));
    check("t4_to_code", 64'(error_code),  64'(2'b11));
    check("t4_to_idle", 64'(busy),        64'(0));

    // Address byte on the terminal-count cycle wins.
    cyc(1, 8'h02, 1);
    for (int i = 1; i < 15; i++) cyc(0, 8'h00, 1);
    cyc(1, 8'h21, 1);
    check("t4_tc_no_ev", 64'(error_valid), 64'(0));
    cyc(0, 8'h00, 0);
    check("t4_tc_valid", 64'(request_valid), 64'(1));
    check("t4_tc_sel",   64'(device_selector), 64'(32'h2));
    cyc(0, 8'h00, 1);

    // Handshake coincident with a new request byte.
    cyc(1, 8'h01, 0);
    cyc(1, 8'h20, 0);
    cyc(0, 8'h00, 0);
    cyc(1, 8'h04, 1);
    check("t5_retired", 64'(request_valid), 64'(0));
    check("t5_busy",    64'(busy),          64'(1));
    cyc(1, 8'h21, 1);
    cyc(0, 8'h00, 0);
    check("t5_req", 64'(request),         64'(8'h04));
    check("t5_sel", 64'(device_selector), 64'(32'h2));
    cyc(0, 8'h00, 1);

    // Asynchronous reset mid-WAIT_ADDRESS and mid-ISSUE.
    cyc(1, 8'h05, 0);
    @(negedge clock);
    #1 reset = 1'b1;
    #1 check_all_zero("t6_wait");
    @(negedge clock);
    reset = 1'b0;
    cyc(1, 8'h01, 0);
    cyc(1, 8'h22, 0);
    cyc(0, 8'h00, 0);
    @(negedge clock);
    #1 reset = 1'b1;
    #1 check_all_zero("t6_issue");
    @(negedge clock);
    reset = 1'b0;
    cyc(1, 8'h00, 1);
    cyc(1, 8'h20, 1);
    cyc(0, 8'h00, 1);
    check("t6_fresh_valid", 64'(request_valid),   64'(1));
    check("t6_fresh_sel",   64'(device_selector), 64'(32'h1));

    // Randomized traffic, checked every cycle by the compare process.
    for (int seg = 0; seg < 80; seg++) begin
      p_req = ($urandom_range(3) == 0) ? 4 : 45;
      p_rdy = $urandom_range(90, 15);
      for (int c = 0; c < 40; c++) begin
        h    = ($urandom_range(99) < p_req);
        r    = ($urandom_range(99) < p_rdy);
        pick = $urandom_range(2);
        if (pick == 0)      d = 8'($urandom_range(10));
        else if (pick == 1) d = 8'($urandom_range(8'h48, 8'h18));
        else                d = 8'($urandom);
        cyc(h, d, r);
      end
    end

    cyc(0, 8'h00, 1);
    repeat (3) cyc(0, 8'h00, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/request_decoder.md
Name: request_decoder

Overview:
Parametrised successor of the two-byte client request handler. Receives the request byte and then the address byte from the UART receive path. Validates both bytes and maps the address onto a one-hot selector over NUM_DEVICES sensors. Presents the decoded command to the sensor side with a valid/ready handshake, and reports malformed, late or overrunning requests on an error strobe.

Parameters:
NUM_DEVICES, 32, number of sensor slots; width of device_selector (1..256)
BASE_ADDRESS, 8'h20, address of slot 0; slot k answers to BASE_ADDRESS+k
MAX_REQUEST, 8'h07, highest legal request code; codes above it are rejected
TIMEOUT_CYCLES, 1_000_000, clock cycles allowed between request byte and address byte (>=2)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
has_request  input  1  one-cycle strobe: received_data holds a new byte
received_data  input  8  byte from UART receiver
request_ready  input  1  sensor side accepts the current command
request  output  8  latched request code
device_selector  output  NUM_DEVICES  one-hot selected sensor
request_valid  output  1  request/device_selector hold a validated command
error_valid  output  1  one-cycle strobe: request rejected
error_code  output  2  00 overrun, 01 bad address, 10 bad command, 11 timeout
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset, asynchronous and immediate, including mid-transaction: state=IDLE; request, device_selector, request_valid, error_valid, error_code, timeout counter and address register all 0.
- States: IDLE, WAIT_ADDRESS, CHECK, ISSUE.
- IDLE: on has_request, capture received_data into request, clear timeout counter, go to WAIT_ADDRESS.
- WAIT_ADDRESS: the counter increments each cycle without has_request.
  - On has_request: capture the address, go to CHECK.
  - If the counter reaches TIMEOUT_CYCLES-1 with no byte: error_valid=1, error_code=11, go to IDLE.
  - has_request on the same cycle as the terminal count wins; no timeout is reported.
- CHECK: single cycle, evaluates the captured bytes.
  - Address outside [BASE_ADDRESS, BASE_ADDRESS+NUM_DEVICES-1]: error 01. Compare in 9 bits so no wrap past 8'hFF.
  - Else request > MAX_REQUEST: error 10. Address error takes priority when both bytes are bad.
  - On any error: device_selector <= 0, go to IDLE.
  - Else: device_selector <= one-hot at bit (address-BASE_ADDRESS), request_valid <= 1, go to ISSUE.
- Latency: the address byte is sampled at edge E. request_valid or error_valid is high from edge E+1.
- error_valid is high for exactly one cycle per rejection; error_code holds its value until the next error.
- ISSUE:
  - request, device_selector and request_valid are held stable until request_ready=1.
  - On handshake: request_valid <= 0, go to IDLE. device_selector stays set, so the sensor remains enabled, until the next CHECK outcome.
  - has_request while request_ready=0: the byte is dropped, error_valid=1, error_code=00, request_valid stays high.
  - has_request on the handshake cycle: handshake completes, the byte is captured as the new request byte, go to WAIT_ADDRESS.
- has_request during CHECK: the byte is dropped and error 00 is pulsed. If CHECK also fails on that cycle, the CHECK error code wins; only one strobe is issued.
- busy is decoded from state; all other outputs are registered.
- Timeout counter width: clog2(TIMEOUT_CYCLES).

Test Plan:
1. Bench parameters BASE=8'h20, NUM_DEVICES=32, MAX_REQUEST=8'h07, TIMEOUT_CYCLES=16. Bytes 8'h03 then 8'h20, ready held 1 -> request=8'h03, device_selector=32'h1, request_valid high for 1 cycle from address edge+1, then state IDLE.
2. Bytes 8'h01, 8'h3F, ready low 5 cycles -> device_selector=32'h8000_0000; request_valid stays high and outputs stay stable for 5 cycles; drops the cycle after ready=1. Same sequence with an extra byte during the wait -> error_code=00 pulse, command unaffected.
3. Bytes 8'h01, 8'h40 -> error_valid pulse, error_code=01, device_selector=0, request_valid never high. Bytes 8'h09, 8'h20 -> error_code=10. Bytes 8'h09, 8'h1F -> error_code=01 (address priority).
4. Byte 8'h02, then silence -> after exactly 15 further cycles error_code=11 pulse, busy falls. Second byte arriving on the terminal-count cycle -> no timeout, normal decode.
5. Handshake cycle coincident with has_request=8'h04, followed by 8'h21 -> first command retires, second decodes to device_selector=32'h2 with request=8'h04.
6. reset asserted asynchronously mid-WAIT_ADDRESS and mid-ISSUE -> all outputs 0 before the next clock edge. After release, a fresh 8'h00/8'h20 pair decodes normally.
